// File: rtl/pwr_seq_ctrl.sv
// Power sequencer for two supply rails: ordered bring-up, alarm/disable
// shutdown in reverse order, bounded retries, lockout and panel LEDs.
module pwr_seq_ctrl #(
    parameter int CW        = 24,
    parameter int T_ON1     = 1000000,
    parameter int T_SETTLE  = 1000000,
    parameter int T_OFF     = 500000,
    parameter int T_HOLD    = 8000000,
    parameter int DEB_CYC   = 1000,
    parameter int MAX_RETRY = 3,
    parameter int HB_BIT    = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr_fault,
    input  logic       avariya,
    output logic       pwr1,
    output logic       pwr2,
    output logic [3:0] led,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [3:0] retry_cnt
);

    localparam int DW = $clog2(DEB_CYC + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEQ1 = 3'd1,
        SEQ2 = 3'd2,
        RUN  = 3'd3,
        SHDN = 3'd4,
        HOLD = 3'd5,
        LOCK = 3'd6
    } state_t;

    localparam logic [CW-1:0] LD_ON1    = CW'(T_ON1 - 1);
    localparam logic [CW-1:0] LD_SETTLE = CW'(T_SETTLE - 1);
    localparam logic [CW-1:0] LD_OFF    = CW'(T_OFF - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC);
    localparam logic [3:0]    RETRY_END = 4'(MAX_RETRY - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HB_BIT:0] hb_q, hb_d;
    logic [3:0]    retry_q, retry_d;
    logic          fault_q, fault_d;
    logic          cause_alarm_q, cause_alarm_d;
    logic          alarm;
    logic          done;

    assign alarm = (dcnt_q == DEB_MAX);
    assign done  = (timer_q == '0);

    always_comb begin
        state_d       = state_q;
        timer_d       = done ? timer_q : timer_q - CW'(1);
        cause_alarm_d = cause_alarm_q;
        fault_d       = clr_fault ? 1'b0 : fault_q;
        retry_d       = retry_q;
        hb_d          = hb_q + 1'b1;
        if (!avariya) begin
            dcnt_d = '0;
        end else if (alarm) begin
            dcnt_d = dcnt_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (en && !alarm && !fault_q) begin
                    state_d = SEQ1;
                    timer_d = LD_ON1;
                end
            end
            SEQ1, SEQ2, RUN: begin
                // Alarm outranks both disable and a timer expiry.
                if (alarm) begin
                    state_d       = SHDN;
                    timer_d       = LD_OFF;
                    cause_alarm_d = 1'b1;
                    fault_d       = 1'b1;
                end else if (!en) begin
                    state_d       = SHDN;
                    timer_d       = LD_OFF;
                    cause_alarm_d = 1'b0;
                end else if (done && state_q == SEQ1) begin
                    state_d = SEQ2;
                    timer_d = LD_SETTLE;
                end else if (done && state_q == SEQ2) begin
                    state_d = RUN;
                end
            end
            SHDN: begin
                if (done) begin
                    if (!cause_alarm_q) begin
                        state_d = IDLE;
                    end else begin
                        if (retry_q != 4'hf) begin
                            retry_d = retry_q + 4'd1;
                        end
                        if (retry_q == RETRY_END) begin
                            state_d = LOCK;
                        end else begin
                            state_d = HOLD;
                            timer_d = LD_HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (clr_fault) begin
                    state_d = IDLE;
                end else if (done) begin
                    if (en && !alarm) begin
                        state_d = SEQ1;
                        timer_d = LD_ON1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCK: begin
                if (clr_fault) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_fault) begin
            retry_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            dcnt_q        <= '0;
            hb_q          <= '0;
            retry_q       <= 4'd0;
            fault_q       <= 1'b0;
            cause_alarm_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            dcnt_q        <= dcnt_d;
            hb_q          <= hb_d;
            retry_q       <= retry_d;
            fault_q       <= fault_d;
            cause_alarm_q <= cause_alarm_d;
        end
    end

    assign pwr1 = (state_q == SEQ1) || (state_q == SEQ2) ||
                  (state_q == RUN)  || (state_q == SHDN);
    assign pwr2 = (state_q == SEQ2) || (state_q == RUN);

    always_comb begin
        led[0] = hb_q[HB_BIT];
        led[1] = pwr1;
        led[2] = pwr2;
        if (state_q == HOLD) begin
            led[3] = hb_q[HB_BIT];
        end else if (state_q == LOCK) begin
            led[3] = 1'b1;
        end else begin
            led[3] = fault_q;
        end
    end

    assign fault     = fault_q;
    assign state_o   = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Bench for pwr_seq_ctrl: vector table, directed corner sequences and
// random stimulus against an elapsed-time reference model.
module tb_pwr_seq_ctrl;

    localparam int T_ON1     = 4;
    localparam int T_SETTLE  = 3;
    localparam int T_OFF     = 5;
    localparam int T_HOLD    = 8;
    localparam int DEB_CYC   = 3;
    localparam int MAX_RETRY = 2;
    localparam int HB_BIT    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr_fault = 1'b0;
    logic       avariya = 1'b0;
    logic       pwr1, pwr2, fault;
    logic [3:0] led;
    logic [2:0] state_o;
    logic [3:0] retry_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pwr_seq_ctrl #(
        .CW(24), .T_ON1(T_ON1), .T_SETTLE(T_SETTLE), .T_OFF(T_OFF),
        .T_HOLD(T_HOLD), .DEB_CYC(DEB_CYC), .MAX_RETRY(MAX_RETRY),
        .HB_BIT(HB_BIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_fault(clr_fault),
        .avariya(avariya), .pwr1(pwr1), .pwr2(pwr2), .led(led),
        .fault(fault), .state_o(state_o), .retry_cnt(retry_cnt)
    );

    // Reference model: tracks time spent in each phase and the length of
    // the current alarm run rather than down-counters.
    int m_st, m_age, m_run, m_retry, m_cyc;
    bit m_fault, m_cause_alarm;

    function automatic int dur(int s);
        case (s)
            1: return T_ON1;
            2: return T_SETTLE;
            4: return T_OFF;
            5: return T_HOLD;
            default: return 1 << 30;
        endcase
    endfunction

    task automatic model_edge(bit r, bit e, bit c, bit a);
        int  nst, rn;
        bit  alarm, finished, fn;
        if (!r) begin
            m_st = 0; m_age = 0; m_run = 0; m_retry = 0; m_cyc = 0;
            m_fault = 0; m_cause_alarm = 0;
            return;
        end
        alarm    = (m_run >= DEB_CYC);
        finished = (m_age + 1 >= dur(m_st));
        nst = m_st;
        fn  = c ? 1'b0 : m_fault;
        rn  = m_retry;
        case (m_st)
            0: if (e && !alarm && !m_fault) nst = 1;
            1, 2, 3: begin
                if (alarm) begin
                    nst = 4; m_cause_alarm = 1; fn = 1;
                end else if (!e) begin
                    nst = 4; m_cause_alarm = 0;
                end else if (m_st != 3 && finished) begin
                    nst = m_st + 1;
                end
            end
            4: if (finished) begin
                if (!m_cause_alarm) nst = 0;
                else begin
                    rn  = (m_retry < 15) ? m_retry + 1 : 15;
                    nst = (m_retry + 1 >= MAX_RETRY) ? 6 : 5;
                end
            end
            5: if (c) nst = 0;
               else if (finished) nst = (e && !alarm) ? 1 : 0;
            6: if (c) nst = 0;
            default: nst = 0;
        endcase
        if (c) rn = 0;
        m_age   = (nst != m_st) ? 0 : m_age + 1;
        m_st    = nst;
        m_fault = fn;
        m_retry = rn;
        m_run   = a ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        m_cyc++;
    endtask

    function automatic logic [13:0] model_vec();
        logic p1, p2, hb, l3;
        p1 = (m_st >= 1 && m_st <= 4);
        p2 = (m_st == 2 || m_st == 3);
        hb = 1'((m_cyc >> HB_BIT) & 1);
        l3 = (m_st == 5) ? hb : (m_st == 6) ? 1'b1 : m_fault;
        return {3'(m_st), 4'(m_retry), m_fault, p1, p2, l3, p2, p1, hb};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {state_o, retry_cnt, fault, pwr1, pwr2, led};
    endfunction

    task automatic chk(string name, logic [13:0] act, logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(string name);
        @(posedge clk);
        model_edge(rst_n, en, clr_fault, avariya);
        #1;
        chk(name, dut_vec(), model_vec());
    endtask

    task automatic run(int n, string name);
        for (int i = 0; i < n; i++) step(name);
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1;
        step("clr_pulse");
        clr_fault = 1'b0;
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] st;
        logic [3:0] led;
    } vec_t;

    vec_t tab[23];

    initial begin
        int st_tab[23] = '{0,1,1,1,1,2,2,2,3,3,4,4,4,4,4,0,1,1,1,1,2,0,0};
        for (int r = 0; r < 23; r++) begin
            logic p1, p2, hb;
            int   hbv;
            hbv = (r == 21) ? 0 : (r == 22) ? 1 : r;
            p1  = (st_tab[r] >= 1 && st_tab[r] <= 4);
            p2  = (st_tab[r] == 2 || st_tab[r] == 3);
            hb  = 1'((hbv >> 3) & 1);
            tab[r].rst_n = !(r == 0 || r == 21);
            tab[r].en    = (r >= 1 && r <= 9) || (r >= 16 && r <= 21);
            tab[r].st    = 3'(st_tab[r]);
            tab[r].led   = {1'b0, p2, p1, hb};
        end

        for (int r = 0; r < 23; r++) begin
            rst_n = tab[r].rst_n;
            en    = tab[r].en;
            step("tab_model");
            chk($sformatf("tab_row%0d", r),
                {state_o, retry_cnt, fault, pwr1, pwr2, led},
                {tab[r].st, 4'd0, 1'b0, tab[r].led[1], tab[r].led[2],
                 tab[r].led});
        end

        // Alarm glitch shorter than the debounce window, then a real alarm.
        en = 1'b1;
        run(8, "seqA_up");
        chk("seqA_run", 14'(state_o), 14'd3);
        avariya = 1'b1; run(2, "glitch");
        avariya = 1'b0; run(1, "glitch");
        chk("glitch_ignored", 14'(state_o), 14'd3);
        avariya = 1'b1; run(3, "deb");
        chk("pre_alarm_pwr2", 14'(pwr2), 14'd1);
        avariya = 1'b0; step("alarm");
        chk("alarm_cut", 14'({pwr1, pwr2, fault}), 14'b101);
        run(4, "shdn");
        chk("shdn_pwr1", 14'(pwr1), 14'd1);
        step("shdn_end");
        chk("to_hold", 14'({state_o, retry_cnt, pwr1}), {7'd0, 3'd5, 4'd1, 1'b0});
        en = 1'b0;
        run(7, "hold");
        chk("hold_len", 14'(state_o), 14'd5);
        step("hold_exit");
        chk("hold_idle", 14'({state_o, fault, led[3], retry_cnt}),
            {5'd0, 3'd0, 1'b1, 1'b1, 4'd1});
        en = 1'b1;
        run(2, "blocked");
        chk("blocked", 14'(state_o), 14'd0);
        pulse_clr();
        chk("clr_idle", 14'({state_o, fault, retry_cnt}), 14'd0);
        step("restart");
        chk("restart", 14'(state_o), 14'd1);

        // Alarm lands on the same edge as the SEQ1 timer expiry.
        avariya = 1'b1; run(3, "seqB_deb");
        avariya = 1'b0; step("seqB_alarm");
        chk("alarm_beats_timer", 14'(state_o), 14'd4);
        run(5, "seqB_shdn");
        chk("seqB_hold", 14'({state_o, retry_cnt}), {7'd0, 3'd5, 4'd1});
        run(8, "seqB_hold");
        chk("hold_retry", 14'({state_o, fault}), {11'd0, 3'd1} << 1 | 14'd1);
        avariya = 1'b1; run(3, "seqB_deb2");
        avariya = 1'b0; run(6, "seqB_shdn2");
        chk("lock", 14'({state_o, retry_cnt, led[3]}), {6'd0, 3'd6, 4'd2, 1'b1});
        run(10, "lock_stay");
        chk("lock_stay", 14'({state_o, led[3]}), {10'd0, 3'd6, 1'b1});
        pulse_clr();
        chk("lock_clr", 14'({state_o, fault, retry_cnt}), 14'd0);

        // Disable and alarm on the same edge: alarm is the cause.
        run(8, "seqC_up");
        chk("seqC_run", 14'(state_o), 14'd3);
        avariya = 1'b1; run(3, "seqC_deb");
        avariya = 1'b0; en = 1'b0; step("seqC_both");
        chk("both_fault", 14'({state_o, fault}), {10'd0, 3'd4, 1'b1});
        run(5, "seqC_shdn");
        chk("both_hold", 14'({state_o, retry_cnt}), {7'd0, 3'd5, 4'd1});
        run(8, "seqC_idle");
        pulse_clr();

        // Reset during SEQ2 drops both rails immediately.
        en = 1'b1;
        run(6, "seqD_up");
        chk("seqD_seq2", 14'(state_o), 14'd2);
        rst_n = 1'b0; step("seqD_rst");
        chk("rst_mid", 14'({state_o, pwr1, pwr2, fault, retry_cnt}), 14'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) avariya = ~avariya;
            en        = ($urandom_range(0, 15) != 0);
            clr_fault = ($urandom_range(0, 63) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
